// File: rtl/pipe_pkg.sv
// Shared constants for elastic pipeline stages: stage state encoding, bubble payload,
// default performance-counter width.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  // 2'd3 is unused and steers back to ST_EMPTY

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; sticks at all-ones, cleared only by rst.
// Latency: count visible one cycle after inc; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic stage register with 2-entry skid, flush-to-bubble and saturating stall counter.
// Latency 1 cycle; in_ready depends only on registered state, rst and flush (never out_ready).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              SIZE      = 32,
  parameter logic [SIZE-1:0] RST_VALUE = {SIZE{1'b0}},
  parameter int              CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  data_out,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]      state;
  logic [SIZE-1:0] main_q;
  logic [SIZE-1:0] skid_q;
  logic            in_fire;
  logic            out_fire;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = !rst && !flush && (state != ST_FULL);
  assign data_out  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= RST_VALUE;
      skid_q <= RST_VALUE;
    end else if (flush) begin
      // skid contents are dead once state is EMPTY; reload keeps it deterministic
      state  <= ST_EMPTY;
      main_q <= RST_VALUE;
      skid_q <= RST_VALUE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state  <= ST_BUSY;
            main_q <= data_in;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= data_in;
          end else if (in_fire) begin
            state  <= ST_FULL;
            skid_q <= data_in;
          end else if (out_fire) begin
            state  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state  <= ST_BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised elastic pipeline stage register, successor to the plain load-enabled stage register. Replaces the single load-enable with a valid/ready handshake and a 2-entry skid buffer. Adds a synchronous flush that injects a bubble value and a saturating stall counter. Sits between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so back-pressure is absorbed locally instead of by a global stall wire.

Parameters:
SIZE, 32, payload width in bits (≥1)
RST_VALUE, {SIZE{1'b0}}, payload loaded on reset and flush (bubble, e.g. RV32 NOP 32'h0000_0013)
CNT_W, 16, stall counter width (≥1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous squash of stage contents
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept this cycle
data_in  in  SIZE  upstream payload
out_valid  out  1  data_out holds a valid payload
out_ready  in  1  downstream accepts this cycle
data_out  out  SIZE  payload to next stage
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives data_out) and skid register, each SIZE bits.
- State machine: EMPTY, BUSY (main valid), FULL (main and skid valid).
- Outputs from state:
  - out_valid = (state != EMPTY), registered.
  - in_ready = !rst & !flush & (state != FULL), combinational from registered state plus rst/flush only. No path from out_ready to in_ready.
- Reset (rst=1 at edge):
  - state <= EMPTY; main and skid <= RST_VALUE; stall_cnt <= 0.
  - While rst=1: in_ready=0. First cycle after reset: out_valid=0, data_out=RST_VALUE, in_ready=1.
- Transitions (rst=0, flush=0):
  - EMPTY: in_fire → BUSY, main<=data_in. Otherwise hold.
  - BUSY:
    - in_fire & out_fire → BUSY, main<=data_in.
    - in_fire & !out_ready → FULL, skid<=data_in, main unchanged.
    - !in_fire & out_fire → EMPTY, main unchanged.
    - Otherwise hold.
  - FULL: in_ready=0. out_fire → BUSY, main<=skid. Otherwise hold.
- Latency and throughput:
  - Latency data_in→data_out is 1 cycle when EMPTY, or when BUSY with out_ready=1.
  - Sustained throughput is 1 payload/cycle.
  - Payload order is strictly FIFO; no payload is dropped or duplicated.
- Stability: while out_valid & !out_ready, data_out and out_valid hold unchanged (absent flush/rst).
- Flush (rst=0, flush=1 at edge):
  - state <= EMPTY; main <= RST_VALUE; skid contents discarded.
  - in_ready=0 in the flush cycle, so no upstream payload is accepted.
  - out_valid is not masked in the flush cycle; if out_ready=1, that out_fire counts as a completed transfer (the downstream side decides).
- Simultaneous rst & flush: rst wins; the result is identical anyway, except that stall_cnt is cleared.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Cleared only by rst; unaffected by flush.
  - The stall cycle coincident with a flush still counts.
- Width rules: payload passes unmodified; no arithmetic on data. Counter increment is CNT_W wide with a saturation compare.

Decomposition:
- Shared package pipe_pkg:
  - State enum: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2; 2'd3 is illegal and recovers to EMPTY.
  - Constant RV32_NOP=32'h0000_0013.
  - Default CNT_W.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated for stall_cnt and reusable for other performance counters.

Test Plan:
- Reset then streaming: SIZE=32, out_ready=1, in_valid=1 with 1,2,3,4 on consecutive cycles → data_out 1,2,3,4 one cycle later each; in_ready stays 1; stall_cnt=0.
- Back-pressure into skid: send 0xA then 0xB with out_ready=0 → state FULL, in_ready=0, data_out=0xA held. Raise out_ready for two cycles → 0xA then 0xB delivered, back to EMPTY.
- Flush while FULL: hold 0xA/0xB, assert flush for one cycle → out_valid=0 and data_out=RST_VALUE next cycle, 0xB never appears, in_ready=0 during the flush cycle.
- Reset mid-operation: rst=1 while FULL with in_valid=1 → next cycle out_valid=0, data_out=RST_VALUE, stall_cnt=0. The payload offered during rst is not accepted.
- Stall counter saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles → stall_cnt counts 1..7 and then holds 7. A subsequent flush leaves it at 7.
- Random handshake: random in_valid/out_ready over 10k cycles against a reference queue model → no loss, no duplication, order preserved; data_out stable whenever out_valid & !out_ready.
